// File: rtl/bitscan_encoder.sv
// Sequential bit-scan encoder: latches a request vector and emits the index of each set bit, one per handshake.
// Optional BITSCAN_COUNT_EN adds a `count` output tracking the number of set bits still pending.
module bitscan_encoder #(
  parameter int WIDTH     = 8,
  parameter int IDX_W     = $clog2(WIDTH),
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [IDX_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             zero_seen
`ifdef BITSCAN_COUNT_EN
  ,
  output logic [IDX_W:0]   count
`endif
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_vec;
  logic             r_zeroSeen;
  logic [IDX_W-1:0] w_idx;
  logic [WIDTH-1:0] w_pickMask;
  logic [WIDTH-1:0] w_vecMinusOne;
  logic             w_oneLeft;

`ifdef BITSCAN_COUNT_EN
  logic [IDX_W:0]   r_count;
  logic [IDX_W:0]   w_popcount;
`endif

  // The last set bit visited wins, so the scan direction decides the priority.
  always_comb begin
    w_idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_vec[i]) w_idx = IDX_W'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (r_vec[i]) w_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_pickMask    = {{(WIDTH-1){1'b0}}, 1'b1} << w_idx;
    w_vecMinusOne = r_vec - {{(WIDTH-1){1'b0}}, 1'b1};
    w_oneLeft     = (r_vec != '0) && ((r_vec & w_vecMinusOne) == '0);
  end

`ifdef BITSCAN_COUNT_EN
  always_comb begin
    w_popcount = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_popcount = w_popcount + {{IDX_W{1'b0}}, din[i]};
    end
  end

  assign count = r_count;
`endif

  assign din_ready  = (r_state == IDLE);
  assign dout_valid = (r_state == SCAN);
  assign dout       = dout_valid ? w_idx : '0;
  assign dout_last  = dout_valid && w_oneLeft;
  assign zero_seen  = r_zeroSeen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_vec      <= '0;
      r_zeroSeen <= 1'b0;
`ifdef BITSCAN_COUNT_EN
      r_count    <= '0;
`endif
    end else begin
      r_zeroSeen <= 1'b0;
      case (r_state)
        IDLE: begin
          if (din_valid) begin
            if (din != '0) begin
              r_vec   <= din;
              r_state <= SCAN;
`ifdef BITSCAN_COUNT_EN
              r_count <= w_popcount;
`endif
            end else begin
              r_zeroSeen <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (dout_ready) begin
            r_vec <= r_vec & ~w_pickMask;
`ifdef BITSCAN_COUNT_EN
            r_count <= r_count - {{IDX_W{1'b0}}, 1'b1};
`endif
            if (w_oneLeft) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitscan_encoder.sv
// Self-checking bench for bitscan_encoder: MSB-first and LSB-first instances share stimulus,
// a queue scoreboard holds the expected index stream for each.
module tb_bitscan_encoder;
  localparam int WIDTH = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             dout_ready;

  logic [IDX_W-1:0] doutM, doutL;
  logic             rdyM, rdyL, dvM, dvL, lastM, lastL, zM, zL;
`ifdef BITSCAN_COUNT_EN
  logic [IDX_W:0]   cntM, cntL;
`endif

  bitscan_encoder #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dutMsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdyM),
    .dout(doutM), .dout_valid(dvM), .dout_ready(dout_ready), .dout_last(lastM),
    .zero_seen(zM)
`ifdef BITSCAN_COUNT_EN
    , .count(cntM)
`endif
  );

  bitscan_encoder #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dutLsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdyL),
    .dout(doutL), .dout_valid(dvL), .dout_ready(dout_ready), .dout_last(lastL),
    .zero_seen(zL)
`ifdef BITSCAN_COUNT_EN
    , .count(cntL)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int last;
    int cnt;
  } exp_t;

  typedef struct {
    logic [7:0] din;
    int         expHs;
    int         expFirstM;
    int         expFirstL;
  } vec_t;

  exp_t qM[$];
  exp_t qL[$];
  int   passCount = 0;
  int   checkCount = 0;
  int   expZero = 0;
  int   hsCount;
  int   firstM, firstL;

  task automatic chk(input string name, input int act, input int exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected index stream for one accepted vector, in both priority orders.
  task automatic pushVector(input logic [7:0] v);
    int remaining;
    exp_t e;
    remaining = 0;
    for (int i = 0; i < WIDTH; i++) if (v[i]) remaining++;
    for (int i = WIDTH - 1, r = remaining; i >= 0; i--) begin
      if (v[i]) begin
        e.idx = i; e.last = (r == 1); e.cnt = r;
        qM.push_back(e);
        r--;
      end
    end
    for (int i = 0, r = remaining; i < WIDTH; i++) begin
      if (v[i]) begin
        e.idx = i; e.last = (r == 1); e.cnt = r;
        qL.push_back(e);
        r--;
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] v, input logic valid);
    din       = v;
    din_valid = valid;
  endtask

  task automatic checkOutput();
    int busy;
    busy = (qM.size() != 0);
    chk("din_ready_msb", rdyM, !busy);
    chk("din_ready_lsb", rdyL, !busy);
    chk("dout_valid_msb", dvM, busy);
    chk("dout_valid_lsb", dvL, busy);
    chk("zero_seen_msb", zM, expZero);
    chk("zero_seen_lsb", zL, expZero);
    if (busy) begin
      chk("dout_msb", doutM, qM[0].idx);
      chk("dout_lsb", doutL, qL[0].idx);
      chk("dout_last_msb", lastM, qM[0].last);
      chk("dout_last_lsb", lastL, qL[0].last);
`ifdef BITSCAN_COUNT_EN
      chk("count_msb", cntM, qM[0].cnt);
      chk("count_lsb", cntL, qL[0].cnt);
      chk("count1_is_last", (cntM == 1), lastM);
`endif
    end else begin
      chk("dout_idle_msb", doutM, 0);
      chk("dout_idle_lsb", doutL, 0);
      chk("dout_last_idle", lastM, 0);
`ifdef BITSCAN_COUNT_EN
      chk("count_idle", cntM, 0);
`endif
    end
  endtask

  // One clock: check pre-edge outputs, then advance the model by what the edge does.
  task automatic cycle();
    logic acc, accZero, hs;
    checkOutput();
    acc     = (qM.size() == 0) && din_valid && (din != 8'h00);
    accZero = (qM.size() == 0) && din_valid && (din == 8'h00);
    hs      = (qM.size() != 0) && dout_ready;
    @(posedge clk);
    #1;
    expZero = accZero;
    if (hs) begin
      if (hsCount == 0) begin
        firstM = qM[0].idx;
        firstL = qL[0].idx;
      end
      qM.delete(0);
      qL.delete(0);
      hsCount++;
    end
    if (acc) pushVector(din);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (qM.size() != 0 && n < 40) begin
      cycle();
      n++;
    end
    if (n >= 40) chk({name, "_drain_timeout"}, 1, 0);
  endtask

  vec_t vecs[7];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{8'hA5, 4, 7, 0};
    vecs[1] = '{8'h80, 1, 7, 7};
    vecs[2] = '{8'h01, 1, 0, 0};
    vecs[3] = '{8'hFF, 8, 7, 0};
    vecs[4] = '{8'h3C, 4, 5, 2};
    vecs[5] = '{8'h00, 0, -1, -1};
    vecs[6] = '{8'h42, 2, 6, 1};

    rst = 1'b1;
    hsCount = 0;
    applyStimulus(8'h00, 1'b0);
    dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_din_ready", rdyM, 1);
    chk("reset_dout_valid", dvM, 0);
    chk("reset_dout", doutM, 0);
    chk("reset_zero_seen", zM, 0);
    chk("reset_dout_last", lastM, 0);
    rst = 1'b0;
    dout_ready = 1'b1;
    repeat (2) cycle();

    for (int r = 0; r < 7; r++) begin
      hsCount = 0;
      firstM = -1;
      firstL = -1;
      applyStimulus(vecs[r].din, 1'b1);
      cycle();
      applyStimulus(8'h00, 1'b0);
      if (vecs[r].din == 8'h00) chk("zero_pulse", zM, 1);
      drain("table");
      cycle();
      chk("hs_count", hsCount, vecs[r].expHs);
      chk("first_msb", firstM, vecs[r].expFirstM);
      chk("first_lsb", firstL, vecs[r].expFirstL);
    end

    // Stall the consumer while the LSB-first instance is presenting index 2.
    hsCount = 0;
    applyStimulus(8'hA5, 1'b1);
    cycle();
    applyStimulus(8'h00, 1'b0);
    cycle();
    dout_ready = 1'b0;
    repeat (3) begin
      cycle();
      chk("stall_idx_lsb", doutL, 2);
      chk("stall_idx_msb", doutM, 5);
      chk("stall_valid", dvL, 1);
    end
    dout_ready = 1'b1;
    drain("stall");
    chk("stall_hs_count", hsCount, 4);
    cycle();

    // Second vector held on din_valid during a scan is taken only after the idle bubble.
    hsCount = 0;
    applyStimulus(8'hFF, 1'b1);
    cycle();
    applyStimulus(8'h01, 1'b1);
    drain("ff");
    chk("bubble_din_ready", rdyM, 1);
    chk("bubble_dout_valid", dvM, 0);
    chk("ff_hs_count", hsCount, 8);
    cycle();
    applyStimulus(8'h00, 1'b0);
    chk("second_valid", dvM, 1);
    chk("second_dout", doutM, 0);
    chk("second_last", lastM, 1);
    drain("second");
    cycle();

    // Asynchronous reset in the middle of a scan abandons the vector.
    hsCount = 0;
    applyStimulus(8'hA5, 1'b1);
    cycle();
    applyStimulus(8'h00, 1'b0);
    cycle();
    #2 rst = 1'b1;
    #1;
    chk("midreset_dout_valid_msb", dvM, 0);
    chk("midreset_dout_valid_lsb", dvL, 0);
    chk("midreset_din_ready", rdyM, 1);
    chk("midreset_dout", doutM, 0);
    qM.delete();
    qL.delete();
    expZero = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) cycle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
